vga_scroll_timing: RTL and testbench
====================================

// Module: vga_scroll_timing
// PURPOSE
//  Generates VGA raster timing and pixel coordinates for the display pipeline.
//  Drives DrawX/DrawY/blank into the background and sprite renderers, and hs/vs to the VGA pins.
//  Keeps a per-frame horizontal scroll offset (scroll_x) for the scrolling level background.
//  Also keeps a frame counter and a vertical-blank pulse, which the game logic uses as its tick.
// PARAMETERS
//  H_ACTIVE     640  visible pixels per line
//  H_FP         16   horizontal front porch, in pixels
//  H_SYNC       96   hsync pulse width, in pixels
//  H_BP         48   horizontal back porch; H_TOTAL = sum of the four = 800
//  V_ACTIVE     480  visible lines per frame
//  V_FP         10   vertical front porch, in lines
//  V_SYNC       2    vsync pulse width, in lines
//  V_BP         33   vertical back porch; V_TOTAL = sum of the four = 525
//  SCROLL_WRAP  500  scroll_x modulus (background image width in texels)
// PORTS
//  vga_clk      in   1   pixel clock (25 MHz nominal)
//  reset_n      in   1   asynchronous reset, active low
//  scroll_en    in   1   1 = advance scroll_x at each vblank_start
//  scroll_step  in   4   pixels to advance per frame; sampled on the vblank_start cycle
//  DrawX        out  10  current pixel column, 0..H_TOTAL-1
//  DrawY        out  10  current pixel row, 0..V_TOTAL-1
//  blank        out  1   1 = visible region (DrawX<H_ACTIVE and DrawY<V_ACTIVE)
//  hs           out  1   horizontal sync, active low
//  vs           out  1   vertical sync, active low
//  vblank_start out  1   one-cycle pulse at the first blanked line
//  frame_count  out  16  number of completed frames, wraps at 2^16
//  scroll_x     out  9   scroll offset, 0..SCROLL_WRAP-1
// BEHAVIOUR
//  - One clock (vga_clk). Reset is asynchronous, active-low (reset_n).
//  - All outputs are registered. No combinational path from any input to any output.
//  - Reset values:
//      DrawX=0, DrawY=0, blank=0, hs=1, vs=1, vblank_start=0, frame_count=0, scroll_x=0.
//  - Internal counters h_cnt and v_cnt reset to 0.
//  - The outputs for counter state (h,v) appear on the cycle after that state is held.
//  - Therefore, in the first cycle after reset release, the outputs show DrawX=0, DrawY=0, blank=1.
//  - h_cnt increments every cycle.
//  - When h_cnt==H_TOTAL-1: h_cnt goes to 0 and v_cnt increments.
//  - When v_cnt==V_TOTAL-1 at that same wrap: v_cnt goes to 0 (end of frame).
//  - Output decodes, taken from the same counter sample as DrawX and DrawY:
//      hs=0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
//      vs=0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
//      vblank_start=1 iff DrawX==0 and DrawY==V_ACTIVE. Exactly one cycle per frame.
//  - frame_count increments on the vblank_start cycle. It wraps from 0xFFFF to 0.
//  - scroll_x update:
//      Happens on the vblank_start cycle, only when scroll_en=1.
//      Computation: sum = scroll_x + scroll_step, in 10 bits.
//      If sum >= SCROLL_WRAP, scroll_x <= sum - SCROLL_WRAP; otherwise scroll_x <= sum.
//      The new value is visible on the cycle after vblank_start.
//      scroll_x is therefore constant throughout every visible region (no tearing).
//      scroll_en=0 or scroll_step=0 leaves scroll_x unchanged.
//      scroll_en and scroll_step are ignored on all other cycles.
//  - Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously).
//    After release, the raster restarts at (0,0). No partial-line state is kept.
//  - Period at defaults: line = 800 cycles; frame = 420000 cycles.
// TESTING
//  - Reset: hold reset_n=0 for 5 cycles -> all outputs equal their reset values.
//    The first cycle after release shows DrawX=0, DrawY=0, blank=1, hs=1, vs=1.
//  - Line timing:
//      DrawX runs 0..799 and then returns to 0.
//      hs=0 for exactly 96 consecutive cycles, starting at DrawX=656.
//      blank=1 for exactly 640 cycles per visible line.
//  - Frame timing:
//      vblank_start period = 420000 cycles, asserted at DrawX=0, DrawY=480.
//      vs=0 for exactly 1600 cycles, starting at DrawX=0, DrawY=490.
//      frame_count goes 0->1->2 over 2 frames.
//  - Scroll wrap: scroll_en=1, scroll_step=5, run 100 frames -> scroll_x=0.
//    Preload to 498 via frames -> the next vblank gives 3. scroll_x never changes while blank=1.
//  - Scroll gating: scroll_en=0 for 3 frames -> scroll_x is unchanged.
//    Toggling scroll_step outside vblank_start has no effect.
//  - Reset mid-frame at DrawY=200, DrawX=300:
//      Outputs go to reset values in the same cycle.
//      After release, the next vblank_start arrives 384000 cycles later (480*800).

Source files
------------

// File: rtl/vga_scroll_timing.sv
// VGA raster timing generator with registered pixel coordinates, syncs, a frame counter
// and a per-frame horizontal scroll offset that only moves during vertical blanking.
module vga_scroll_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCROLL_WRAP = 500
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        scroll_en,
    input  logic [3:0]  scroll_step,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        vblank_start,
    output logic [15:0] frame_count,
    output logic [8:0]  scroll_x
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WRAP     = 10'(SCROLL_WRAP);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  draw_x_q, draw_y_q;
    logic        blank_q, hs_q, vs_q, vblank_start_q;
    logic [15:0] frame_count_q, frame_count_d;
    logic [8:0]  scroll_x_q, scroll_x_d;
    logic [9:0]  scroll_sum;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        h_cnt_d       = h_cnt_q + 10'd1;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q + {15'd0, vblank_start_q};
        scroll_sum    = {1'b0, scroll_x_q} + {6'd0, scroll_step};
        scroll_x_d    = scroll_x_q;

        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end

        // Scroll only moves while the registered vblank pulse is high, so it is frozen all frame.
        if (vblank_start_q && scroll_en) begin
            scroll_x_d = (scroll_sum >= WRAP) ? 9'(scroll_sum - WRAP) : scroll_sum[8:0];
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            draw_x_q       <= '0;
            draw_y_q       <= '0;
            blank_q        <= 1'b0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '0;
            scroll_x_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every decode below sees the pre-edge counters.
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            draw_x_q       <= h_cnt_q;
            draw_y_q       <= v_cnt_q;
            blank_q        <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            hs_q           <= !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
            vs_q           <= !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
            vblank_start_q <= (h_cnt_q == '0) && (v_cnt_q == V_ACT);
            frame_count_q  <= frame_count_d;
            scroll_x_q     <= scroll_x_d;
        end
    end

    assign DrawX        = draw_x_q;
    assign DrawY        = draw_y_q;
    assign blank        = blank_q;
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;
    assign scroll_x     = scroll_x_q;

endmodule

// File: tb/tb_vga_scroll_timing.sv
// Directed bench: one default-geometry instance for line timing, and one reduced-geometry
// instance (25x15 raster, 375-cycle frame) so frame, scroll and reset behaviour fit in a short run.
module tb_vga_scroll_timing;

    // Reduced geometry: H 16/2/4/3 = 25, V 8/2/2/3 = 15, frame = 375 cycles.
    localparam int HT = 25;
    localparam int VT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scroll_en = 1'b0;
    logic [3:0] scroll_step = 4'd0;

    logic [9:0]  s_x, s_y, d_x, d_y;
    logic        s_blank, s_hs, s_vs, s_vb;
    logic        d_blank, d_hs, d_vs, d_vb;
    logic [15:0] s_fc, d_fc;
    logic [8:0]  s_sx, d_sx;

    int checks = 0;
    int failures = 0;
    int tear_errs = 0;
    logic [8:0] last_sx = '0;

    always #5 clk = ~clk;

    vga_scroll_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SCROLL_WRAP(500)
    ) dut (
        .vga_clk(clk), .reset_n(rst_n), .scroll_en(scroll_en), .scroll_step(scroll_step),
        .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
        .vblank_start(s_vb), .frame_count(s_fc), .scroll_x(s_sx)
    );

    vga_scroll_timing dut_def (
        .vga_clk(clk), .reset_n(rst_n), .scroll_en(1'b0), .scroll_step(4'd0),
        .DrawX(d_x), .DrawY(d_y), .blank(d_blank), .hs(d_hs), .vs(d_vs),
        .vblank_start(d_vb), .frame_count(d_fc), .scroll_x(d_sx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One negedge sample; also watches for scroll_x moving during the visible region.
    task automatic tick();
        @(negedge clk);
        if (s_blank === 1'b1 && s_sx !== last_sx) tear_errs++;
        last_sx = s_sx;
    endtask

    task automatic wait_vblank(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (s_vb !== 1'b1 && n < 2000);
    endtask

    // Pass nf vblank pulses, then one more sample so the updated scroll_x is visible.
    task automatic run_frames(input int nf);
        int n;
        for (int i = 0; i < nf; i++) begin
            wait_vblank(n);
            if (n > HT * VT) check("run_frames_vblank_timeout", n, HT * VT);
        end
        tick();
    endtask

    // Wiggle scroll inputs every non-vblank cycle; at the vblank cycle present a no-op setting.
    task automatic toggle_frame(input bit gate_en);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * HT * VT && !seen; k++) begin
            if (s_vb === 1'b1) begin
                scroll_en   = gate_en ? 1'b0 : 1'b1;
                scroll_step = gate_en ? 4'd7 : 4'd0;
                seen = 1'b1;
            end else begin
                scroll_en   = 1'b1;
                scroll_step = 4'((k % 15) + 1);
            end
            tick();
        end
        check("toggle_frame_vblank_seen", 32'(seen), 1);
        scroll_en = 1'b0;
    endtask

    initial begin
        int n, xerr, hs_low, hs_first, blank_cnt, vs_low, vs_fx, vs_fy, vb_at;

        // Reset held 5 cycles
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_drawx", s_x, 0);
        check("rst_drawy", s_y, 0);
        check("rst_blank", s_blank, 0);
        check("rst_hs", s_hs, 1);
        check("rst_vs", s_vs, 1);
        check("rst_vblank", s_vb, 0);
        check("rst_frame_count", s_fc, 0);
        check("rst_scroll_x", s_sx, 0);
        check("rst_def_blank", d_blank, 0);
        check("rst_def_hs", d_hs, 1);

        rst_n = 1'b1;
        tick();
        check("first_drawx", s_x, 0);
        check("first_drawy", s_y, 0);
        check("first_blank", s_blank, 1);
        check("first_hs", s_hs, 1);
        check("first_vs", s_vs, 1);
        check("first_def_blank", d_blank, 1);

        // One full line at default geometry
        xerr = 0; hs_low = 0; hs_first = -1; blank_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_x !== 10'(i) || d_y !== 10'd0) xerr++;
            if (d_hs === 1'b0) begin
                if (hs_first < 0) hs_first = int'(d_x);
                hs_low++;
            end
            if (d_blank === 1'b1) blank_cnt++;
            tick();
        end
        check("def_drawx_sequence_errors", xerr, 0);
        check("def_hs_low_cycles", hs_low, 96);
        check("def_hs_first_x", hs_first, 656);
        check("def_blank_cycles", blank_cnt, 640);
        check("def_wrap_drawx", d_x, 0);
        check("def_wrap_drawy", d_y, 1);

        // Fresh reset for the reduced-geometry frame tests
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        last_sx = '0;
        tick();
        wait_vblank(n);
        check("first_vblank_latency", n, 8 * HT);
        check("vblank_drawx", s_x, 0);
        check("vblank_drawy", s_y, 8);
        check("vblank_frame_count", s_fc, 0);

        vs_low = 0; vs_fx = -1; vs_fy = -1; hs_low = 0; blank_cnt = 0; vb_at = -1;
        for (int j = 1; j <= HT * VT; j++) begin
            tick();
            if (j == 1) begin
                check("frame_count_after_vb1", s_fc, 1);
                check("vblank_one_cycle", s_vb, 0);
            end
            if (s_vs === 1'b0) begin
                if (vs_fx < 0) begin
                    vs_fx = int'(s_x);
                    vs_fy = int'(s_y);
                end
                vs_low++;
            end
            if (s_hs === 1'b0) hs_low++;
            if (s_blank === 1'b1) blank_cnt++;
            if (s_vb === 1'b1 && vb_at < 0) vb_at = j;
        end
        check("vs_low_cycles", vs_low, 2 * HT);
        check("vs_first_x", vs_fx, 0);
        check("vs_first_y", vs_fy, 10);
        check("hs_low_cycles_per_frame", hs_low, 4 * VT);
        check("blank_cycles_per_frame", blank_cnt, 16 * 8);
        check("vblank_period", vb_at, HT * VT);
        tick();
        check("frame_count_after_vb2", s_fc, 2);

        // Scroll accumulation and wrap
        scroll_en = 1'b1;
        scroll_step = 4'd5;
        run_frames(1);
        check("scroll_after_1", s_sx, 5);
        run_frames(99);
        check("scroll_wrap_100x5", s_sx, 0);
        scroll_step = 4'd15;
        run_frames(33);
        check("scroll_preload_495", s_sx, 495);
        scroll_step = 4'd3;
        run_frames(1);
        check("scroll_preload_498", s_sx, 498);
        scroll_step = 4'd5;
        run_frames(1);
        check("scroll_wrap_498_plus_5", s_sx, 3);

        // Gating
        scroll_en = 1'b0;
        scroll_step = 4'd9;
        run_frames(3);
        check("scroll_en0_3_frames", s_sx, 3);
        toggle_frame(1'b0);
        check("scroll_step_toggle_ignored", s_sx, 3);
        toggle_frame(1'b1);
        check("scroll_en_toggle_ignored", s_sx, 3);
        check("scroll_no_tearing", tear_errs, 0);
        check("frame_count_total", s_fc, 142);

        // Asynchronous reset in the middle of the visible region
        n = 0;
        while (!(s_y === 10'd5 && s_x === 10'd10) && n < 1000) begin
            tick();
            n++;
        end
        check("midframe_position_found", 32'(n < 1000), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_drawx", s_x, 0);
        check("async_rst_drawy", s_y, 0);
        check("async_rst_blank", s_blank, 0);
        check("async_rst_frame_count", s_fc, 0);
        check("async_rst_scroll_x", s_sx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_sx = '0;
        tick();
        check("restart_drawx", s_x, 0);
        check("restart_drawy", s_y, 0);
        wait_vblank(n);
        check("restart_vblank_latency", n, 8 * HT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
